// File: rtl/digit_encoder_if.sv
// Handshake bundle between a score producer/result consumer and digit_encoder.
// master: drives start/clear, scores and ack; slave: the encoder itself.
interface digit_encoder_if #(
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned IDX_W   = 4
);
  logic               rst_digit;
  logic               en_digit;
  logic               score_valid;
  logic [SCORE_W-1:0] score_data;
  logic               score_ready;
  logic [IDX_W-1:0]   digit_code;
  logic               digit_valid;
  logic               digit_ack;
  logic               busy;

  modport master (
    output rst_digit, en_digit, score_valid, score_data, digit_ack,
    input  score_ready, digit_code, digit_valid, busy
  );

  modport slave (
    input  rst_digit, en_digit, score_valid, score_data, digit_ack,
    output score_ready, digit_code, digit_valid, busy
  );
endinterface

// File: rtl/digit_encoder.sv
// Streaming argmax over NUM_CLASSES signed scores; emits the winning class index.
// Optional macro DIGIT_TIE_DETECT_EN adds a 'tie' output flagging a repeated maximum.
module digit_encoder #(
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DIGIT_TIE_DETECT_EN
  output logic              tie,
`endif
  digit_encoder_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]          code_q, code_d;

  logic signed [SCORE_W-1:0] score_s;
  logic                      xfer, first, gt, take, last;
  logic [IDX_W-1:0]          new_best_idx;

  assign score_s      = bus.score_data;
  assign xfer         = (state_q == StCollect) && bus.score_valid && !bus.rst_digit;
  assign first        = (idx_q == '0);
  // Direct signed compare: no subtraction, so extreme values cannot overflow.
  assign gt           = score_s > best_q;
  assign take         = first || gt;
  assign last         = (idx_q == IDX_W'(NUM_CLASSES - 1));
  assign new_best_idx = take ? idx_q : best_idx_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    code_d     = code_q;

    unique case (state_q)
      StIdle: begin
        if (bus.en_digit) state_d = StCollect;
      end
      StCollect: begin
        if (xfer) begin
          if (take) begin
            best_d     = score_s;
            best_idx_d = idx_q;
          end
          if (last) begin
            state_d = StHold;
            code_d  = new_best_idx;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StHold: begin
        // en_digit here is ignored; a new frame needs a fresh start in idle.
        if (bus.digit_ack) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.rst_digit) begin
      state_d    = StIdle;
      idx_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
      code_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      code_q     <= code_d;
    end
  end

  assign bus.score_ready = (state_q == StCollect) && !bus.rst_digit;
  assign bus.digit_valid = (state_q == StHold);
  assign bus.busy        = (state_q != StIdle);
  assign bus.digit_code  = code_q;

`ifdef DIGIT_TIE_DETECT_EN
  logic seen_q, seen_d, seen_nxt;
  logic tie_q, tie_d;

  // Sticky "later score equals current max"; a new strict max clears it.
  always_comb begin
    seen_nxt = seen_q;
    if (take)                          seen_nxt = 1'b0;
    else if (score_s == best_q)        seen_nxt = 1'b1;

    seen_d = seen_q;
    tie_d  = tie_q;
    if (xfer) begin
      seen_d = seen_nxt;
      if (last) tie_d = seen_nxt;
    end
    if (state_q == StHold && bus.digit_ack) tie_d = 1'b0;
    if (bus.rst_digit) begin
      seen_d = 1'b0;
      tie_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 1'b0;
      tie_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      tie_q  <= tie_d;
    end
  end

  assign tie = tie_q;
`endif

endmodule
